// File: rtl/alu_mc_if.sv
// Request/response bundle for the multi-cycle execute ALU.
// The master drives operands and drains results; the slave is the ALU.
interface alu_mc_if #(
   parameter int unsigned REG_WIDTH = 64
);
   logic                 in_valid;
   logic                 in_ready;
   logic [REG_WIDTH-1:0] in1;
   logic [REG_WIDTH-1:0] in2;
   logic [3:0]           alu_control;
   logic                 out_valid;
   logic                 out_ready;
   logic [REG_WIDTH-1:0] result;
   logic                 zero;

   modport master (
      output in_valid, in1, in2, alu_control, out_ready,
      input  in_ready, out_valid, result, zero
   );

   modport slave (
      input  in_valid, in1, in2, alu_control, out_ready,
      output in_ready, out_valid, result, zero
   );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: single-cycle logic/arith/shift/compare ops plus
// iterative unsigned mul (shift-add) and divu/remu (restoring), valid/ready on both sides.
module alu_mc #(
   parameter int unsigned REG_WIDTH = 64
) (
   input logic   clk,
   input logic   reset_b,
   alu_mc_if.slave bus
);
   localparam int unsigned SW = $clog2(REG_WIDTH);
   localparam int unsigned CW = SW + 1;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_XOR  = 4'b0011;
   localparam logic [3:0] OP_SLL  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SRA  = 4'b0111;
   localparam logic [3:0] OP_SLT  = 4'b1000;
   localparam logic [3:0] OP_SLTU = 4'b1001;
   localparam logic [3:0] OP_MUL  = 4'b1010;
   localparam logic [3:0] OP_DIVU = 4'b1100;
   localparam logic [3:0] OP_REMU = 4'b1101;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t               state_q, state_d;
   logic [3:0]           op_q, op_d;
   logic [REG_WIDTH-1:0] opa_q, opa_d;      // multiplicand / divisor
   logic [REG_WIDTH-1:0] opb_q, opb_d;      // multiplier / dividend-then-quotient
   logic [REG_WIDTH-1:0] acc_q, acc_d;      // partial product / partial remainder
   logic [REG_WIDTH-1:0] result_q, result_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 in_ready_q, in_ready_d;
   logic                 out_valid_q, out_valid_d;

   logic [REG_WIDTH-1:0] alu_c;
   logic [SW-1:0]        shamt_c;
   logic                 in_mc_c;
   logic [REG_WIDTH-1:0] mul_sum_c;
   logic [REG_WIDTH:0]   rem_sh_c;
   logic                 take_c;
   logic [REG_WIDTH-1:0] rem_nxt_c;
   logic [REG_WIDTH-1:0] quo_nxt_c;

   // Single-cycle result straight from the request operands
   always_comb begin
      alu_c   = '0;
      shamt_c = bus.in2[SW-1:0];
      case (bus.alu_control)
         OP_ADD:  alu_c = bus.in1 + bus.in2;
         OP_SUB:  alu_c = bus.in1 - bus.in2;
         OP_AND:  alu_c = bus.in1 & bus.in2;
         OP_OR:   alu_c = bus.in1 | bus.in2;
         OP_XOR:  alu_c = bus.in1 ^ bus.in2;
         OP_SLL:  alu_c = bus.in1 << shamt_c;
         OP_SRL:  alu_c = bus.in1 >> shamt_c;
         OP_SRA:  alu_c = $signed(bus.in1) >>> shamt_c;
         OP_SLT:  alu_c = {{(REG_WIDTH-1){1'b0}}, ($signed(bus.in1) < $signed(bus.in2))};
         OP_SLTU: alu_c = {{(REG_WIDTH-1){1'b0}}, (bus.in1 < bus.in2)};
         default: alu_c = '0;
      endcase
      in_mc_c = (bus.alu_control == OP_MUL) || (bus.alu_control == OP_DIVU) ||
                (bus.alu_control == OP_REMU);
   end

   // One iteration step; a zero divisor naturally yields all-ones quotient and remainder = in1
   always_comb begin
      mul_sum_c = acc_q + (opb_q[0] ? opa_q : '0);
      rem_sh_c  = {acc_q, opb_q[REG_WIDTH-1]};
      take_c    = (rem_sh_c >= {1'b0, opa_q});
      rem_nxt_c = take_c ? REG_WIDTH'(rem_sh_c - {1'b0, opa_q}) : rem_sh_c[REG_WIDTH-1:0];
      quo_nxt_c = {opb_q[REG_WIDTH-2:0], take_c};
   end

   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         state_q     <= IDLE;
         op_q        <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         acc_q       <= '0;
         result_q    <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         acc_q       <= acc_d;
         result_q    <= result_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      opa_d    = opa_q;
      opb_d    = opb_q;
      acc_d    = acc_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               op_d = bus.alu_control;
               if (in_mc_c) begin
                  opa_d   = (bus.alu_control == OP_MUL) ? bus.in1 : bus.in2;
                  opb_d   = (bus.alu_control == OP_MUL) ? bus.in2 : bus.in1;
                  acc_d   = '0;
                  cnt_d   = CW'(REG_WIDTH);
                  state_d = BUSY;
               end else begin
                  result_d = alu_c;
                  state_d  = DONE;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q - CW'(1);
            if (op_q == OP_MUL) begin
               acc_d = mul_sum_c;
               opa_d = opa_q << 1;
               opb_d = opb_q >> 1;
            end else begin
               acc_d = rem_nxt_c;
               opb_d = quo_nxt_c;
            end
            if (cnt_q == CW'(1)) begin
               if (op_q == OP_MUL)       result_d = mul_sum_c;
               else if (op_q == OP_DIVU) result_d = quo_nxt_c;
               else                      result_d = rem_nxt_c;
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      in_ready_d  = (state_d == IDLE);
      out_valid_d = (state_d == DONE);
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.zero      = (result_q == '0);
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: a 64-bit instance for ALU/mul ops and an 8-bit one for divide.
module tb_alu_mc;
   logic clk = 1'b0;
   logic reset_b;
   always #5 clk = ~clk;

   alu_mc_if #(.REG_WIDTH(64)) if64 ();
   alu_mc_if #(.REG_WIDTH(8))  if8  ();

   alu_mc #(.REG_WIDTH(64)) u_alu64 (.clk(clk), .reset_b(reset_b), .bus(if64));
   alu_mc #(.REG_WIDTH(8))  u_alu8  (.clk(clk), .reset_b(reset_b), .bus(if8));

   // Shared stimulus, steered to one instance by sel8
   logic        sel8;
   logic        valid;
   logic        oready;
   logic [63:0] a, b;
   logic [3:0]  op;

   assign if64.in_valid    = valid & ~sel8;
   assign if64.in1         = a;
   assign if64.in2         = b;
   assign if64.alu_control = op;
   assign if64.out_ready   = oready;
   assign if8.in_valid     = valid & sel8;
   assign if8.in1          = a[7:0];
   assign if8.in2          = b[7:0];
   assign if8.alu_control  = op;
   assign if8.out_ready    = oready;

   logic        rdy, ov, zr;
   logic [63:0] res;
   assign rdy = sel8 ? if8.in_ready  : if64.in_ready;
   assign ov  = sel8 ? if8.out_valid : if64.out_valid;
   assign zr  = sel8 ? if8.zero      : if64.zero;
   assign res = sel8 ? {56'd0, if8.result} : if64.result;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Issue one op with out_ready=1, measure latency, check result and the one-cycle drain
   task automatic run_op(input string tag, input logic [3:0] o, input logic [63:0] x,
                         input logic [63:0] y, input logic [63:0] exp, input int exp_lat);
      int  lat;
      bit  rdy_bad;
      lat     = 0;
      rdy_bad = 1'b0;
      @(negedge clk);
      op = o; a = x; b = y; valid = 1'b1; oready = 1'b1;
      check({tag, "/ready_idle"}, 64'(rdy), 64'd1);
      @(posedge clk);
      #1 valid = 1'b0;
      for (int i = 1; i <= 200; i++) begin
         @(negedge clk);
         if (ov) begin
            lat = i;
            break;
         end
         if (rdy) rdy_bad = 1'b1;
      end
      check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
      check({tag, "/result"}, res, exp);
      check({tag, "/zero"}, 64'(zr), 64'(exp == 64'd0));
      check({tag, "/ready_busy"}, 64'(rdy_bad | rdy), 64'd0);
      @(negedge clk);
      check({tag, "/drained"}, {62'd0, ov, rdy}, 64'b01);
   endtask

   initial begin
      bit stale;
      bit hold_bad;
      sel8 = 1'b0; valid = 1'b0; oready = 1'b1; a = '0; b = '0; op = '0;
      reset_b = 1'b0;
      repeat (2) @(negedge clk);
      check("rst64", {res[61:0], zr, ov, rdy}, {62'd0, 1'b1, 1'b0, 1'b1});
      sel8 = 1'b1;
      #1 check("rst8", {res[61:0], zr, ov, rdy}, {62'd0, 1'b1, 1'b0, 1'b1});
      sel8 = 1'b0;
      reset_b = 1'b1;

      run_op("add_wrap", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1);
      run_op("sub",      4'b0110, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 1);
      run_op("sra63",    4'b0111, 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF, 1);
      run_op("srl",      4'b0101, 64'h100, 64'd4, 64'h10, 1);
      run_op("sll_amt",  4'b0100, 64'd1, 64'd68, 64'd16, 1);
      run_op("and",      4'b0000, 64'hF0F0, 64'hFF00, 64'hF000, 1);
      run_op("or",       4'b0001, 64'hF0F0, 64'hFF00, 64'hFFF0, 1);
      run_op("xor",      4'b0011, 64'hF0F0, 64'hFF00, 64'h0FF0, 1);
      run_op("slt",      4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1, 1);
      run_op("sltu",     4'b1001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1);
      run_op("undef",    4'b1111, 64'd7, 64'd9, 64'd0, 1);
      run_op("mul64",    4'b1010, 64'h1_0000_0001, 64'h1_0000_0001, 64'h2_0000_0001, 65);

      sel8 = 1'b1;
      run_op("divu8",    4'b1100, 64'd200, 64'd7, 64'd28, 9);
      run_op("remu8",    4'b1101, 64'd200, 64'd7, 64'd4, 9);
      run_op("divu8_z",  4'b1100, 64'd9, 64'd0, 64'hFF, 9);
      run_op("remu8_z",  4'b1101, 64'd9, 64'd0, 64'd9, 9);
      run_op("mul8_wrap",4'b1010, 64'd20, 64'd13, 64'd4, 9);
      sel8 = 1'b0;

      // Reset in the 10th BUSY cycle of mul 3x5
      @(negedge clk);
      op = 4'b1010; a = 64'd3; b = 64'd5; valid = 1'b1; oready = 1'b1;
      @(posedge clk);
      #1 valid = 1'b0;
      repeat (10) @(negedge clk);
      reset_b = 1'b0;
      #1 check("rst_mid", {res[61:0], zr, ov, rdy}, {62'd0, 1'b1, 1'b0, 1'b1});
      @(negedge clk);
      reset_b = 1'b1;
      @(negedge clk);
      check("rst_rel_ready", 64'(rdy), 64'd1);
      stale = 1'b0;
      repeat (70) begin
         @(negedge clk);
         if (ov || res != 64'd0) stale = 1'b1;
      end
      check("rst_no_stale", 64'(stale), 64'd0);

      // Back-pressure on add 1+2 with noisy inputs
      @(negedge clk);
      op = 4'b0010; a = 64'd1; b = 64'd2; valid = 1'b1; oready = 1'b0;
      @(posedge clk);
      #1 valid = 1'b0;
      @(negedge clk);
      check("bp_first", {res[61:0], ov, rdy}, {62'd3, 1'b1, 1'b0});
      hold_bad = 1'b0;
      for (int i = 0; i < 5; i++) begin
         a = 64'(i * 11 + 100); b = 64'(i + 40); valid = ~valid;
         @(negedge clk);
         if (res != 64'd3 || !ov || rdy || zr) hold_bad = 1'b1;
      end
      check("bp_hold", 64'(hold_bad), 64'd0);
      valid = 1'b0; oready = 1'b1;
      @(negedge clk);
      check("bp_drain", {62'd0, ov, rdy}, 64'b01);
      @(negedge clk);
      check("bp_no_accept", {62'd0, ov, rdy}, 64'b01);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
